// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format encodings, opcodes and funct3 shift codes for the immediate-generation stage
package imm_gen_pkg;
   localparam logic [2:0] FMT_I     = 3'b000;
   localparam logic [2:0] FMT_S     = 3'b001;
   localparam logic [2:0] FMT_B     = 3'b010;
   localparam logic [2:0] FMT_U     = 3'b011;
   localparam logic [2:0] FMT_J     = 3'b100;
   localparam logic [2:0] FMT_Z     = 3'b101;
   localparam logic [2:0] FMT_SHAMT = 3'b110;
   localparam logic [2:0] FMT_NONE  = 3'b111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SR     = 3'b101;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational format resolution and immediate extension
//   instr    : instruction word
//   auto_dec : 1 = format from opcode, 0 = format from sel
//   sel      : explicit format
//   imm      : XLEN extended immediate
//   fmt      : resolved format
//   illegal  : opcode unknown in auto mode
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic            auto_dec,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);
   logic [6:0] op;
   logic [2:0] f3;
   logic       shift;
   logic       w32;
   logic [2:0] dec_fmt;
   logic       dec_ill;
   assign op    = instr[6:0];
   assign f3    = instr[14:12];
   assign shift = (f3 == F3_SLL) || (f3 == F3_SR);
   // word shifts on RV64 keep a 5-bit shamt even though XLEN is 64
   assign w32   = auto_dec && (op == OP_IMM32);
   always_comb begin
      dec_fmt = FMT_NONE;
      dec_ill = 1'b0;
      case (op)
         OP_IMM:            dec_fmt = shift ? FMT_SHAMT : FMT_I;
         OP_LOAD, OP_JALR:  dec_fmt = FMT_I;
         OP_STORE:          dec_fmt = FMT_S;
         OP_BRANCH:         dec_fmt = FMT_B;
         OP_LUI, OP_AUIPC:  dec_fmt = FMT_U;
         OP_JAL:            dec_fmt = FMT_J;
         OP_SYSTEM:         dec_fmt = f3[2] ? FMT_Z : FMT_I;
         OP_REG, OP_REG32:  dec_fmt = FMT_NONE;
         OP_IMM32: begin
            dec_fmt = (XLEN == 64) ? (shift ? FMT_SHAMT : FMT_I) : FMT_NONE;
            dec_ill = (XLEN != 64);
         end
         default:           dec_ill = 1'b1;
      endcase
   end
   assign fmt     = auto_dec ? dec_fmt : sel;
   assign illegal = auto_dec & dec_ill;
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:     imm = XLEN'($signed(instr[31:20]));
         FMT_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         FMT_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         FMT_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
         FMT_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         FMT_Z:     imm = XLEN'(instr[19:15]);
         FMT_SHAMT: imm = (XLEN == 64 && !w32) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
         default:   imm = '0;
      endcase
   end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered valid/ready immediate stage with 2-entry skid buffer and illegal counter
//   clk, rst_n        : clock, async active-low reset
//   flush             : drop all buffered entries and any simultaneous input
//   in_valid/in_ready : input handshake; in_instr, in_auto, in_sel : input payload
//   out_valid/out_ready : output handshake
//   out_imm, out_instr, out_fmt, out_illegal : registered result
//   illegal_cnt       : saturating count of illegal entries delivered
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             in_auto,
   input  logic [2:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [31:0]      out_instr,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   localparam int EW = XLEN + 36;
   logic [XLEN-1:0] x_imm;
   logic [2:0]      x_fmt;
   logic            x_ill;
   logic [EW-1:0]   main_q, skid_q, new_e;
   logic            main_valid, skid_valid;
   logic            in_fire, out_fire, load;
   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr    (in_instr),
      .auto_dec (in_auto),
      .sel      (in_sel),
      .imm      (x_imm),
      .fmt      (x_fmt),
      .illegal  (x_ill)
   );
   assign new_e = {x_ill, x_fmt, in_instr, x_imm};
   assign {out_illegal, out_fmt, out_instr, out_imm} = main_q;
   assign out_valid = main_valid;
   // skid_valid is a flop, so in_ready is registered
   assign in_ready  = !skid_valid;
   assign in_fire   = in_valid & in_ready & !flush;
   assign out_fire  = main_valid & out_ready;
   assign load      = !main_valid | out_fire;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q      <= '0;
         skid_q      <= '0;
         main_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         illegal_cnt <= '0;
      end else begin
         if (out_fire && out_illegal && illegal_cnt != '1)
            illegal_cnt <= illegal_cnt + CNT_W'(1);
         if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (load) begin
            // skid is only ever full while in_ready is low, so the two sources never collide
            main_valid <= skid_valid | in_fire;
            skid_valid <= 1'b0;
            if (skid_valid)
               main_q <= skid_q;
            else if (in_fire)
               main_q <= new_e;
         end else if (in_fire) begin
            skid_q     <= new_e;
            skid_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed self-checking bench for imm_gen_stage (XLEN=32/CNT_W=2 and XLEN=64)
module tb_imm_gen_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_auto = 1'b1;
   logic [2:0]  in_sel = '0;
   logic        out_ready = 1'b1;
   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_imm, a_out_instr;
   logic [2:0]  a_out_fmt;
   logic [1:0]  a_cnt;
   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [63:0] b_out_imm;
   logic [31:0] b_out_instr;
   logic [2:0]  b_out_fmt;
   logic [15:0] b_cnt;
   int passed = 0;
   int total = 0;
   always #5 clk = ~clk;
   imm_gen_stage #(.XLEN(32), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_auto(in_auto), .in_sel(in_sel), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_imm(a_out_imm), .out_instr(a_out_instr), .out_fmt(a_out_fmt),
      .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
   );
   imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_auto(in_auto), .in_sel(in_sel), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_imm(b_out_imm), .out_instr(b_out_instr), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] w, input logic a, input logic [2:0] s);
      in_valid = 1'b1;
      in_instr = w;
      in_auto  = a;
      in_sel   = s;
      tick();
      in_valid = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      chk("rst_valid", a_out_valid, 0);
      chk("rst_ready", a_in_ready, 1);
      chk("rst_imm", b_out_imm, 0);
      chk("rst_instr", a_out_instr, 0);
      chk("rst_fmt", a_out_fmt, 0);
      chk("rst_ill", a_out_illegal, 0);
      chk("rst_cnt", a_cnt, 0);
      rst_n = 1'b1;
      tick();
      send(32'hFFF00093, 1'b1, 3'b000);
      chk("addi_valid", a_out_valid, 1);
      chk("addi_imm", a_out_imm, 64'hFFFFFFFF);
      chk("addi_fmt", a_out_fmt, 0);
      chk("addi_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFFF);
      send(32'hFFDFF0EF, 1'b1, 3'b000);
      chk("jal_imm", a_out_imm, 64'hFFFFFFFC);
      chk("jal_fmt", a_out_fmt, 4);
      send(32'h00000463, 1'b1, 3'b000);
      chk("beq_imm", a_out_imm, 64'h8);
      chk("beq_fmt", a_out_fmt, 2);
      send(32'h800000B7, 1'b1, 3'b000);
      chk("lui_imm64", b_out_imm, 64'hFFFFFFFF80000000);
      chk("lui_fmt64", b_out_fmt, 3);
      chk("lui_imm32", a_out_imm, 64'h80000000);
      send(32'h03F09093, 1'b1, 3'b000);
      chk("slli_imm64", b_out_imm, 64'h3F);
      chk("slli_fmt64", b_out_fmt, 6);
      chk("slli_imm32", a_out_imm, 64'h1F);
      send(32'h300FD073, 1'b1, 3'b000);
      chk("csr_imm64", b_out_imm, 64'h1F);
      chk("csr_fmt64", b_out_fmt, 5);
      chk("csr_ill64", b_out_illegal, 0);
      // five illegal words back to back
      in_valid = 1'b1;
      in_instr = 32'h0000007F;
      in_auto  = 1'b1;
      tick();
      chk("ill_flag", a_out_illegal, 1);
      chk("ill_imm", a_out_imm, 0);
      chk("ill_fmt", a_out_fmt, 7);
      chk("ill_cnt0", a_cnt, 0);
      tick();
      chk("ill_cnt1", a_cnt, 1);
      tick();
      chk("ill_cnt2", a_cnt, 2);
      tick();
      chk("ill_cnt3", a_cnt, 3);
      tick();
      chk("ill_cnt4", a_cnt, 3);
      in_valid = 1'b0;
      tick();
      chk("ill_cnt5", a_cnt, 3);
      chk("ill_cnt64", b_cnt, 5);
      chk("ill_idle", a_out_valid, 0);
      send(32'h0000007F, 1'b0, 3'b000);
      chk("expl_ill", a_out_illegal, 0);
      chk("expl_fmt", a_out_fmt, 0);
      tick();
      // backpressure: A, B, C with out_ready low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_auto   = 1'b1;
      in_instr  = 32'h00100093;
      tick();
      chk("bp_a_main", a_out_instr, 32'h00100093);
      chk("bp_ready1", a_in_ready, 1);
      in_instr = 32'h00200093;
      tick();
      chk("bp_ready_fall", a_in_ready, 0);
      chk("bp_a_hold", a_out_instr, 32'h00100093);
      in_instr = 32'h00300093;
      tick();
      chk("bp_c_wait", a_in_ready, 0);
      chk("bp_a_stable", a_out_imm, 1);
      out_ready = 1'b1;
      tick();
      chk("bp_b_out", a_out_instr, 32'h00200093);
      chk("bp_b_imm", a_out_imm, 2);
      chk("bp_ready_rise", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("bp_c_out", a_out_instr, 32'h00300093);
      chk("bp_c_valid", a_out_valid, 1);
      tick();
      chk("bp_drain", a_out_valid, 0);
      // flush with two entries held and an input offered
      out_ready = 1'b0;
      send(32'h00400093, 1'b1, 3'b000);
      send(32'h00500093, 1'b1, 3'b000);
      chk("fl_full", a_in_ready, 0);
      in_valid = 1'b1;
      in_instr = 32'h00600093;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", a_out_valid, 0);
      chk("fl_ready", a_in_ready, 1);
      // flush while an input would otherwise be accepted
      in_valid = 1'b1;
      in_instr = 32'h00700093;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("fl_drop", a_out_valid, 0);
      tick();
      chk("fl_never", a_out_valid, 0);
      chk("fl_cnt", a_cnt, 3);
      // asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'hFFF00093, 1'b1, 3'b000);
      chk("ar_pre", a_out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", a_out_valid, 0);
      chk("ar_imm", a_out_imm, 0);
      chk("ar_instr", b_out_instr, 0);
      chk("ar_cnt", a_cnt, 0);
      chk("ar_ready", a_in_ready, 1);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      send(32'hFFDFF0EF, 1'b1, 3'b000);
      chk("ar_post_valid", a_out_valid, 1);
      chk("ar_post_imm", a_out_imm, 64'hFFFFFFFC);
      chk("ar_post_instr", a_out_instr, 32'hFFDFF0EF);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, handshaked immediate-generation stage for the decode pipeline. It accepts a 32-bit instruction with valid/ready and produces a sign- or zero-extended XLEN immediate, the resolved format and an illegal flag, with 1-cycle latency. The immediate format comes either from an explicit selector or from opcode auto-decode. Adds RV64 support, CSR/shamt formats, flush, a 2-entry skid buffer and a saturating illegal-opcode counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
CNT_W, 16, width of the illegal-opcode counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input instruction valid.
in_ready  out  1  stage can accept an instruction.
in_instr  in  32  instruction word.
in_auto  in  1  1 = derive format from opcode; 0 = use in_sel.
in_sel  in  3  explicit format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110 SHAMT, 111 NONE.
out_valid  out  1  output valid.
out_ready  in  1  consumer accepts output.
out_imm  out  XLEN  extended immediate.
out_instr  out  32  instruction passed through.
out_fmt  out  3  resolved format, same encoding as in_sel.
out_illegal  out  1  auto-decode found an unknown opcode.
illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered.

Behaviour:
- Formats (sign bit is instr[31]; sign-extend to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: instr[19:15], zero-extended.
  - SHAMT: instr[25:20] zero-extended when XLEN=64, else instr[24:20].
  - NONE: 0.
- Auto-decode on opcode instr[6:0]:
  - 0010011: SHAMT if funct3 is 001 or 101, else I.
  - 0000011 and 1100111: I.
  - 0100011: S. 1100011: B.
  - 0110111 and 0010111: U. 1101111: J.
  - 1110011: Z if funct3[2]=1, else I.
  - 0110011 and 0111011: NONE.
  - 0011011, XLEN=64 only: SHAMT (5-bit, instr[24:20]) if funct3 is 001 or 101, else I.
  - Any other opcode: fmt NONE, imm 0, out_illegal 1.
- Explicit mode: never sets out_illegal.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - An accepted instruction appears at the output on the next cycle.
  - Throughput is 1 per cycle when out_ready is held high.
  - out_* are stable while out_valid=1 and out_ready=0.
- Skid buffer:
  - Holds a main and a skid entry.
  - in_ready is registered and equals !skid_valid.
  - When out_ready is low, one extra accepted word goes to skid; in_ready then falls.
  - On the first out_ready, main takes the skid contents.
  - Order is preserved; no word is dropped or duplicated.
- flush:
  - Clears both valid bits at the next edge and drops a simultaneous input transfer.
  - Next cycle: out_valid=0, in_ready=1.
  - Does not clear illegal_cnt.
- illegal_cnt:
  - Increments when an output transfer has out_illegal=1.
  - Saturates at all-ones.
  - Not incremented for entries removed by flush.
- Reset (async assert; deassertion sampled on clk): out_valid=0, in_ready=1, out_imm=0, out_instr=0, out_fmt=000, out_illegal=0, illegal_cnt=0. Reset mid-stream discards all buffered entries.

Decomposition:
- Package imm_gen_pkg holds:
  - format encodings (FMT_I..FMT_NONE);
  - opcode constants;
  - funct3 shift codes.
- Sub-module imm_extract, combinational and parametrised by XLEN: instr, auto, sel -> imm, fmt, illegal. It sits before the skid buffer.
- The handshake, skid buffer and counter live in imm_gen_stage.

Test Plan:
- XLEN=32, auto, 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=000. Also 0xFFDFF0EF (jal -4) -> 0xFFFFFFFC, fmt=100. Also 0x00000463 (beq +8) -> 0x00000008, fmt=010.
- XLEN=64, auto:
  - 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt=011.
  - 0x03F09093 (slli x1,x1,63) -> 0x3F, fmt=110.
  - 0x300FD073 (csrrwi, zimm 31) -> 0x1F, fmt=101.
- Backpressure: hold out_ready=0 and offer 3 back-to-back words A, B, C.
  - A occupies main, B is accepted into skid, in_ready falls, C waits.
  - Release out_ready: outputs arrive in order A, B, C with no gaps beyond 1 cycle.
- Flush: assert flush with in_valid=1 while 2 entries are held -> next cycle out_valid=0, in_ready=1, and the input word never appears.
- Illegal: CNT_W=2, auto, send 0x0000007F five times with out_ready=1 -> out_illegal=1, imm=0, fmt=111. illegal_cnt goes 1, 2, 3, 3, 3. The same word with in_auto=0, in_sel=000 gives out_illegal=0.
- Reset: assert rst_n=0 asynchronously mid-stream -> all outputs return to reset values immediately. The first word accepted after release is delivered correctly.
